de_reg: RTL
===========

DE_REG -- requirements
Module: de_reg

Interface
REQ-001 Parameter `NOP_INSTR`, default 32'h0000_0000; instruction word loaded on a bubble.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 en  in  1  1 = load the D-stage bundle; 0 = hold the current contents.
REQ-005 clr  in  1  1 = load a bubble at the next edge (hazard stall or flush).
REQ-006 D_instr  in  32  decoded instruction word.
REQ-007 D_pc  in  32  instruction PC.
REQ-008 D_rs_data  in  32  rs operand after D-stage forwarding.
REQ-009 D_rt_data  in  32  rt operand after D-stage forwarding.
REQ-010 D_imm  in  32  extended immediate from the extender (zero, sign or upper form).
REQ-011 D_a3  in  5  destination register; 0 means no write.
REQ-012 D_tnew  in  2  cycles until the result is available, counted from E entry.
REQ-013 W_we, W_a3, W_wd  in  1/5/32  W-stage write port, used to refresh operands while holding.
REQ-014 E_instr, E_pc, E_rs_data, E_rt_data, E_imm  out  32 each  registered copies of the D-stage fields.
REQ-015 E_a3  out  5 and E_tnew  out  2  registered copies of D_a3 and D_tnew.
REQ-016 E_valid  out  1  1 = a real instruction occupies E; 0 = bubble.
REQ-017 M_tnew  out  2  combinational saturating decrement of E_tnew, passed to the E/M register.

Function
REQ-018 Edge priority, highest first: reset, then clr, then hold (en=0), then load.
REQ-019 Load: every E_* output takes its D_* input at the edge, and E_valid becomes 1.
REQ-020 Bubble (clr=1, whatever en is):
- E_instr becomes NOP_INSTR.
- All other data fields, E_a3 and E_tnew become 0.
- E_valid becomes 0.
REQ-021 Hold (en=0, clr=0): every field keeps its value, except the operand refresh in REQ-022.
REQ-022 Operand refresh during hold:
- If W_we=1, W_a3 is not 0, and W_a3 equals E_instr[25:21], E_rs_data becomes W_wd.
- The same rule applies to E_rt_data using E_instr[20:16].
- Both operands may refresh in the same cycle.
REQ-023 No operand refresh happens on a load or bubble edge; D_* already carries the forwarded values.
REQ-024 Refresh applies only when E_valid=1; a held bubble stays all-zero.
REQ-025 M_tnew = E_tnew - 1 when E_tnew > 0, otherwise 0; it never wraps from 0 to 3.
REQ-026 Latency is one cycle from D_* to E_*; there is no combinational path from D_* to E_*.
REQ-027 The register never alters D_imm in any way; the extension form is fixed upstream.

Reset
REQ-028 On reset=1 at an edge, outputs take the bubble values of REQ-020:
- E_instr = NOP_INSTR, E_valid = 0, all other outputs 0.
REQ-029 Reset overrides clr, en and any refresh in the same cycle.
REQ-030 Reset is honoured mid-operation, including while holding.
REQ-031 Outputs are undefined before the first reset edge; the bench shall not check them.

Structure
REQ-032 The shared CPU package holds:
- field bit positions (RS_MSB/LSB = 25/21, RT_MSB/LSB = 20/16);
- the TNEW width;
- the NOP encoding.
REQ-033 Sub-module `pipe_field`: a width-parameterised register with reset, clear, enable, bubble value and an optional refresh data/strobe.
- de_reg instantiates it once per field.
REQ-034 No other sub-modules; the M_tnew decrement is inline logic.

Verification
REQ-035 Reset then load:
- Stimulus: reset for 1 cycle, then en=1 with D_instr=32'h2008_FFFF, D_imm=32'hFFFF_FFFF, D_a3=8, D_tnew=1.
- Required: E fields match the inputs, E_valid=1, M_tnew=0.
REQ-036 clr and en both high:
- Stimulus: clr=1, en=1 with a valid D bundle.
- Required: E_instr=NOP_INSTR, E_a3=0, E_tnew=0, E_valid=0.
REQ-037 Hold with W write:
- Stimulus: held E_instr has rs=9, rt=10; W_we=1, W_a3=9, W_wd=32'hDEAD_BEEF.
- Required: E_rs_data=32'hDEAD_BEEF, E_rt_data unchanged, all other fields unchanged.
- Repeat with W_a3=0: no change.
REQ-038 Hold with both operands matching:
- Stimulus: rs=rt=5, W_a3=5.
- Required: both operands refresh in the same cycle.
- Repeat on a held bubble: no change.
REQ-039 M_tnew saturation:
- Stimulus: E_tnew = 2, 1, 0 in turn.
- Required: M_tnew = 1, 0, 0.
REQ-040 Reset over clr and hold:
- Stimulus: reset=1 while holding with clr=1 and a matching W write.
- Required: all outputs at reset values, E_valid=0.

Source files
------------

// File: rtl/de_reg_pkg.sv
// ---------------------------------------------------------------
// de_reg_pkg : shared CPU field positions, widths and encodings
// rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package de_reg_pkg;
   localparam int RS_MSB = 25;
   localparam int RS_LSB = 21;
   localparam int RT_MSB = 20;
   localparam int RT_LSB = 16;
   localparam int TNEW_W = 2;
   localparam int REG_W  = 5;
   localparam int XLEN   = 32;
   localparam logic [XLEN-1:0] NOP = 32'h0000_0000;

   typedef logic [TNEW_W-1:0] tnew_t;
   typedef logic [REG_W-1:0]  regaddr_t;
   typedef logic [XLEN-1:0]   word_t;
endpackage

`default_nettype wire

// File: rtl/de_reg_if.sv
// ---------------------------------------------------------------
// de_reg_if : D-stage bundle in, E-stage bundle out, W write port
// rev 1.0
// ---------------------------------------------------------------
`default_nettype none

interface de_reg_if;
   import de_reg_pkg::*;

   logic     en;
   logic     clr;
   word_t    D_instr;
   word_t    D_pc;
   word_t    D_rs_data;
   word_t    D_rt_data;
   word_t    D_imm;
   regaddr_t D_a3;
   tnew_t    D_tnew;
   logic     W_we;
   regaddr_t W_a3;
   word_t    W_wd;
   word_t    E_instr;
   word_t    E_pc;
   word_t    E_rs_data;
   word_t    E_rt_data;
   word_t    E_imm;
   regaddr_t E_a3;
   tnew_t    E_tnew;
   logic     E_valid;
   tnew_t    M_tnew;

   modport master (
      output en, clr, D_instr, D_pc, D_rs_data, D_rt_data, D_imm, D_a3, D_tnew,
             W_we, W_a3, W_wd,
      input  E_instr, E_pc, E_rs_data, E_rt_data, E_imm, E_a3, E_tnew, E_valid,
             M_tnew
   );

   modport slave (
      input  en, clr, D_instr, D_pc, D_rs_data, D_rt_data, D_imm, D_a3, D_tnew,
             W_we, W_a3, W_wd,
      output E_instr, E_pc, E_rs_data, E_rt_data, E_imm, E_a3, E_tnew, E_valid,
             M_tnew
   );
endinterface

`default_nettype wire

// File: rtl/de_reg_pipe_field.sv
// ---------------------------------------------------------------
// pipe_field : one pipeline field with reset/clear/enable/refresh
// rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module pipe_field #(
   parameter int         WIDTH  = 32,
   parameter logic [WIDTH-1:0] BUBBLE = '0
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             clr,
   input  wire logic             en,
   input  wire logic [WIDTH-1:0] d,
   input  wire logic             rf_we,
   input  wire logic [WIDTH-1:0] rf_d,
   output logic      [WIDTH-1:0] q
);
   // refresh only matters while holding; load and bubble take precedence
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         q <= BUBBLE;
      end else if (en) begin
         q <= d;
      end else if (rf_we) begin
         q <= rf_d;
      end
   end
endmodule

`default_nettype wire

// File: rtl/de_reg.sv
// ---------------------------------------------------------------
// de_reg : D/E pipeline register with bubble insert and W refresh
// rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module de_reg
   import de_reg_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP
) (
   input wire logic clk,
   input wire logic reset,
   de_reg_if.slave  bus
);
   logic w_rs_hit;
   logic w_rt_hit;
   logic w_wr_any;

   // a held instruction must see results retiring from W while it waits
   assign w_wr_any = bus.W_we && (bus.W_a3 != '0) && bus.E_valid;
   assign w_rs_hit = w_wr_any && (bus.W_a3 == bus.E_instr[RS_MSB:RS_LSB]);
   assign w_rt_hit = w_wr_any && (bus.W_a3 == bus.E_instr[RT_MSB:RT_LSB]);

   pipe_field #(.WIDTH(XLEN), .BUBBLE(NOP_INSTR)) u_instr (
      .clk(clk), .reset(reset), .clr(bus.clr), .en(bus.en),
      .d(bus.D_instr), .rf_we(1'b0), .rf_d('0), .q(bus.E_instr));

   pipe_field #(.WIDTH(XLEN)) u_pc (
      .clk(clk), .reset(reset), .clr(bus.clr), .en(bus.en),
      .d(bus.D_pc), .rf_we(1'b0), .rf_d('0), .q(bus.E_pc));

   pipe_field #(.WIDTH(XLEN)) u_rs (
      .clk(clk), .reset(reset), .clr(bus.clr), .en(bus.en),
      .d(bus.D_rs_data), .rf_we(w_rs_hit), .rf_d(bus.W_wd), .q(bus.E_rs_data));

   pipe_field #(.WIDTH(XLEN)) u_rt (
      .clk(clk), .reset(reset), .clr(bus.clr), .en(bus.en),
      .d(bus.D_rt_data), .rf_we(w_rt_hit), .rf_d(bus.W_wd), .q(bus.E_rt_data));

   pipe_field #(.WIDTH(XLEN)) u_imm (
      .clk(clk), .reset(reset), .clr(bus.clr), .en(bus.en),
      .d(bus.D_imm), .rf_we(1'b0), .rf_d('0), .q(bus.E_imm));

   pipe_field #(.WIDTH(REG_W)) u_a3 (
      .clk(clk), .reset(reset), .clr(bus.clr), .en(bus.en),
      .d(bus.D_a3), .rf_we(1'b0), .rf_d('0), .q(bus.E_a3));

   pipe_field #(.WIDTH(TNEW_W)) u_tnew (
      .clk(clk), .reset(reset), .clr(bus.clr), .en(bus.en),
      .d(bus.D_tnew), .rf_we(1'b0), .rf_d('0), .q(bus.E_tnew));

   pipe_field #(.WIDTH(1)) u_valid (
      .clk(clk), .reset(reset), .clr(bus.clr), .en(bus.en),
      .d(1'b1), .rf_we(1'b0), .rf_d(1'b0), .q(bus.E_valid));

   assign bus.M_tnew = (bus.E_tnew == '0) ? '0 : bus.E_tnew - tnew_t'(1);
endmodule

`default_nettype wire
